// File: rtl/amt_restore_if.sv
// Retire-port bundle between the ROB and the architectural map table:
// commit requests downstream, ready and released tags back upstream.
interface amt_restore_if #(
    parameter int unsigned RT_NUM    = 2,
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned PHY_REGS  = 64
);
    localparam int unsigned AW    = $clog2(ARCH_REGS);
    localparam int unsigned TAG_W = $clog2(PHY_REGS);

    logic [RT_NUM-1:0]            rt_wr_en;
    logic [RT_NUM-1:0][AW-1:0]    rt_arch_reg;
    logic [RT_NUM-1:0][TAG_W-1:0] rt_phy_tag;
    logic                         rt_rdy;
    logic [RT_NUM-1:0]            rel_valid;
    logic [RT_NUM-1:0][TAG_W-1:0] rel_tag;

    modport master (
        output rt_wr_en, rt_arch_reg, rt_phy_tag,
        input  rt_rdy, rel_valid, rel_tag
    );

    modport slave (
        input  rt_wr_en, rt_arch_reg, rt_phy_tag,
        output rt_rdy, rel_valid, rel_tag
    );
endinterface

// File: rtl/amt_restore.sv
// Architectural map table: commits retired mappings, releases displaced tags
// and streams the committed table back to the speculative map on rollback.
module amt_restore #(
    parameter int unsigned RT_NUM    = 2,
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned PHY_REGS  = 64,
    parameter int unsigned RST_BW    = 4,
    parameter int unsigned ZERO_REG  = 1,
    localparam int unsigned AW       = $clog2(ARCH_REGS),
    localparam int unsigned TAG_W    = $clog2(PHY_REGS)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    amt_restore_if.slave                     rt_if,
    input  logic                             rollback_i,
    output logic [ARCH_REGS-1:0][TAG_W-1:0]  amt_o,
    output logic                             rst_valid_o,
    output logic [AW-1:0]                    rst_idx_o,
    output logic [RST_BW-1:0][TAG_W-1:0]     rst_tags_o,
    output logic                             rst_done_o,
    output logic                             busy_o
);
    localparam int unsigned NBEATS    = ARCH_REGS / RST_BW;
    localparam int unsigned BEAT_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    typedef enum logic {IDLE, RESTORE} state_t;

    state_t                          r_state;
    logic [BEAT_W-1:0]               r_beat;
    logic [ARCH_REGS-1:0][TAG_W-1:0] r_amt;
    logic                            r_rdy;
    logic                            r_busy;
    logic                            r_rst_valid;
    logic                            r_rst_done;
    logic [AW-1:0]                   r_rst_idx;
    logic [RST_BW-1:0][TAG_W-1:0]    r_rst_tags;

    logic [RT_NUM-1:0]               w_live;
    logic [ARCH_REGS-1:0][TAG_W-1:0] w_amt_nxt;
    logic [RT_NUM-1:0]               w_rel_valid;
    logic [RT_NUM-1:0][TAG_W-1:0]    w_rel_tag;
    logic [BEAT_W-1:0]               w_nb;
    logic [AW-1:0]                   w_base;
    logic [RST_BW-1:0][TAG_W-1:0]    w_nb_tags;

    // A channel takes effect only in IDLE, out of reset, and not targeting a hardwired r0
    always_comb begin
        w_live = '0;
        for (int c = 0; c < RT_NUM; c++) begin
            w_live[c] = (r_state == IDLE) && !rst_i && rt_if.rt_wr_en[c] &&
                        !((ZERO_REG != 0) && (rt_if.rt_arch_reg[c] == '0));
        end
    end

    // Commit in channel order so the youngest writer of a register wins;
    // released tag forwards from the youngest older channel hitting the same register
    always_comb begin
        w_amt_nxt   = r_amt;
        w_rel_valid = '0;
        w_rel_tag   = '0;
        for (int c = 0; c < RT_NUM; c++) begin
            if (w_live[c]) begin
                w_amt_nxt[rt_if.rt_arch_reg[c]] = rt_if.rt_phy_tag[c];
            end
        end
        for (int c = 0; c < RT_NUM; c++) begin
            w_rel_valid[c] = w_live[c];
            w_rel_tag[c]   = r_amt[rt_if.rt_arch_reg[c]];
            for (int k = 0; k < c; k++) begin
                if (w_live[k] && (rt_if.rt_arch_reg[k] == rt_if.rt_arch_reg[c])) begin
                    w_rel_tag[c] = rt_if.rt_phy_tag[k];
                end
            end
        end
    end

    // Next beat's tags come from the post-commit table so a rollback-cycle commit is visible
    always_comb begin
        w_nb   = (r_state == IDLE) ? '0 : (r_beat + BEAT_W'(1));
        w_base = AW'(32'(w_nb) * RST_BW);
        for (int j = 0; j < RST_BW; j++) begin
            w_nb_tags[j] = w_amt_nxt[w_base + AW'(j)];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_beat      <= '0;
            for (int i = 0; i < ARCH_REGS; i++) begin
                r_amt[i] <= TAG_W'(i);
            end
            r_rdy       <= 1'b1;
            r_busy      <= 1'b0;
            r_rst_valid <= 1'b0;
            r_rst_done  <= 1'b0;
            r_rst_idx   <= '0;
            r_rst_tags  <= '0;
        end else begin
            r_amt <= w_amt_nxt;
            case (r_state)
                IDLE: begin
                    if (rollback_i) begin
                        r_state     <= RESTORE;
                        r_beat      <= '0;
                        r_rdy       <= 1'b0;
                        r_busy      <= 1'b1;
                        r_rst_valid <= 1'b1;
                        r_rst_idx   <= '0;
                        r_rst_tags  <= w_nb_tags;
                        r_rst_done  <= (LAST_BEAT == '0);
                    end
                end
                RESTORE: begin
                    if (r_beat == LAST_BEAT) begin
                        r_state     <= IDLE;
                        r_beat      <= '0;
                        r_rdy       <= 1'b1;
                        r_busy      <= 1'b0;
                        r_rst_valid <= 1'b0;
                        r_rst_done  <= 1'b0;
                    end else begin
                        r_beat      <= w_nb;
                        r_rst_valid <= 1'b1;
                        r_rst_idx   <= w_base;
                        r_rst_tags  <= w_nb_tags;
                        r_rst_done  <= (w_nb == LAST_BEAT);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rt_if.rt_rdy    = r_rdy;
    assign rt_if.rel_valid = w_rel_valid;
    assign rt_if.rel_tag   = w_rel_tag;
    assign amt_o           = r_amt;
    assign rst_valid_o     = r_rst_valid;
    assign rst_idx_o       = r_rst_idx;
    assign rst_tags_o      = r_rst_tags;
    assign rst_done_o      = r_rst_done;
    assign busy_o          = r_busy;
endmodule

// File: tb/tb_amt_restore.sv
// Directed bench for amt_restore: commits, releases, forwarding, rollback
// streaming, stalls during restore and reset mid-stream.
module tb_amt_restore;
    localparam int unsigned RT_NUM    = 2;
    localparam int unsigned ARCH_REGS = 32;
    localparam int unsigned PHY_REGS  = 64;
    localparam int unsigned RST_BW    = 4;
    localparam int unsigned AW        = 5;
    localparam int unsigned TAG_W     = 6;

    logic                            clk_i = 1'b0;
    logic                            rst_i;
    logic                            rollback_i;
    logic [ARCH_REGS-1:0][TAG_W-1:0] amt_o;
    logic                            rst_valid_o;
    logic [AW-1:0]                   rst_idx_o;
    logic [RST_BW-1:0][TAG_W-1:0]    rst_tags_o;
    logic                            rst_done_o;
    logic                            busy_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [TAG_W-1:0] exp_amt [ARCH_REGS];

    always #5 clk_i = ~clk_i;

    amt_restore_if #(.RT_NUM(RT_NUM), .ARCH_REGS(ARCH_REGS), .PHY_REGS(PHY_REGS)) rt_if ();

    amt_restore #(
        .RT_NUM(RT_NUM), .ARCH_REGS(ARCH_REGS), .PHY_REGS(PHY_REGS),
        .RST_BW(RST_BW), .ZERO_REG(1)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rt_if      (rt_if.slave),
        .rollback_i (rollback_i),
        .amt_o      (amt_o),
        .rst_valid_o(rst_valid_o),
        .rst_idx_o  (rst_idx_o),
        .rst_tags_o (rst_tags_o),
        .rst_done_o (rst_done_o),
        .busy_o     (busy_o)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive(input int ch, input logic en, input logic [AW-1:0] ar,
                         input logic [TAG_W-1:0] tg);
        rt_if.rt_wr_en[ch]    = en;
        rt_if.rt_arch_reg[ch] = ar;
        rt_if.rt_phy_tag[ch]  = tg;
    endtask

    task automatic clear_inputs();
        rt_if.rt_wr_en    = '0;
        rt_if.rt_arch_reg = '0;
        rt_if.rt_phy_tag  = '0;
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < ARCH_REGS; i++) begin
            check($sformatf("%s[%0d]", tag, i), 64'(amt_o[i]), 64'(exp_amt[i]));
        end
    endtask

    task automatic check_beat(input int n);
        check($sformatf("beat%0d_valid", n), 64'(rst_valid_o), 64'(1));
        check($sformatf("beat%0d_idx", n), 64'(rst_idx_o), 64'(n * 4));
        check($sformatf("beat%0d_done", n), 64'(rst_done_o), 64'(n == 7));
        check($sformatf("beat%0d_busy", n), 64'(busy_o), 64'(1));
        check($sformatf("beat%0d_rdy", n), 64'(rt_if.rt_rdy), 64'(0));
        check($sformatf("beat%0d_relv", n), 64'(rt_if.rel_valid), 64'(0));
        for (int j = 0; j < RST_BW; j++) begin
            check($sformatf("beat%0d_tag%0d", n, j), 64'(rst_tags_o[j]), 64'(exp_amt[n * 4 + j]));
        end
    endtask

    initial begin
        for (int i = 0; i < ARCH_REGS; i++) exp_amt[i] = TAG_W'(i);
        rst_i      = 1'b1;
        rollback_i = 1'b0;
        clear_inputs();
        drive(0, 1'b1, 5'd4, 6'd20);
        repeat (3) @(negedge clk_i);
        check("relv_in_reset", 64'(rt_if.rel_valid), 64'(0));
        rst_i = 1'b0;
        clear_inputs();
        #1;
        check("rdy_after_reset", 64'(rt_if.rt_rdy), 64'(1));
        check("busy_after_reset", 64'(busy_o), 64'(0));
        check("rstv_after_reset", 64'(rst_valid_o), 64'(0));
        check("done_after_reset", 64'(rst_done_o), 64'(0));
        check("relv_after_reset", 64'(rt_if.rel_valid), 64'(0));
        check_table("amt_reset");

        // distinct registers
        @(negedge clk_i);
        drive(0, 1'b1, 5'd3, 6'd40);
        drive(1, 1'b1, 5'd5, 6'd41);
        #1;
        check("dist_relv", 64'(rt_if.rel_valid), 64'(2'b11));
        check("dist_rel0", 64'(rt_if.rel_tag[0]), 64'(3));
        check("dist_rel1", 64'(rt_if.rel_tag[1]), 64'(5));
        @(negedge clk_i);
        clear_inputs();
        exp_amt[3] = 6'd40;
        exp_amt[5] = 6'd41;
        check("dist_amt3", 64'(amt_o[3]), 64'(40));
        check("dist_amt5", 64'(amt_o[5]), 64'(41));

        // same register in one group
        drive(0, 1'b1, 5'd7, 6'd50);
        drive(1, 1'b1, 5'd7, 6'd51);
        #1;
        check("same_relv", 64'(rt_if.rel_valid), 64'(2'b11));
        check("same_rel0", 64'(rt_if.rel_tag[0]), 64'(7));
        check("same_rel1", 64'(rt_if.rel_tag[1]), 64'(50));
        @(negedge clk_i);
        clear_inputs();
        exp_amt[7] = 6'd51;
        check("same_amt7", 64'(amt_o[7]), 64'(51));

        // writes to r0 are dropped
        drive(0, 1'b1, 5'd0, 6'd33);
        drive(1, 1'b1, 5'd0, 6'd34);
        #1;
        check("r0_relv", 64'(rt_if.rel_valid), 64'(0));
        @(negedge clk_i);
        clear_inputs();
        check("r0_amt0", 64'(amt_o[0]), 64'(0));

        // r0 on ch0 ignored, ch1 commits normally
        drive(0, 1'b1, 5'd0, 6'd33);
        drive(1, 1'b1, 5'd12, 6'd35);
        #1;
        check("mix_relv", 64'(rt_if.rel_valid), 64'(2'b10));
        check("mix_rel1", 64'(rt_if.rel_tag[1]), 64'(12));
        @(negedge clk_i);
        clear_inputs();
        exp_amt[12] = 6'd35;
        check_table("amt_pre_rb");

        // rollback with a same-cycle commit
        drive(0, 1'b1, 5'd2, 6'd60);
        rollback_i = 1'b1;
        #1;
        check("rb_relv", 64'(rt_if.rel_valid), 64'(2'b01));
        check("rb_rel0", 64'(rt_if.rel_tag[0]), 64'(2));
        check("rb_rdy", 64'(rt_if.rt_rdy), 64'(1));
        exp_amt[2] = 6'd60;

        for (int n = 0; n < 8; n++) begin
            @(negedge clk_i);
            rollback_i = 1'b0;
            drive(0, 1'b1, 5'd9, 6'd45);
            drive(1, 1'b1, 5'd10, 6'd46);
            #1;
            check_beat(n);
            if (n == 3) rollback_i = 1'b1;
        end
        @(negedge clk_i);
        clear_inputs();
        rollback_i = 1'b0;
        #1;
        check("post_rstv", 64'(rst_valid_o), 64'(0));
        check("post_done", 64'(rst_done_o), 64'(0));
        check("post_busy", 64'(busy_o), 64'(0));
        check("post_rdy", 64'(rt_if.rt_rdy), 64'(1));
        check_table("amt_post_rb");

        // reset in the middle of a restore stream
        rollback_i = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk_i);
            rollback_i = 1'b0;
            #1;
            check_beat(n);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        #1;
        for (int i = 0; i < ARCH_REGS; i++) exp_amt[i] = TAG_W'(i);
        check("midrst_busy", 64'(busy_o), 64'(0));
        check("midrst_rstv", 64'(rst_valid_o), 64'(0));
        check("midrst_done", 64'(rst_done_o), 64'(0));
        check("midrst_rdy", 64'(rt_if.rt_rdy), 64'(1));
        check_table("amt_midrst");
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("after_rst_rstv", 64'(rst_valid_o), 64'(0));
        check("after_rst_done", 64'(rst_done_o), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/amt_restore.md
Name: amt_restore

Overview:
Parametrised architectural map table (AMT) for the retire stage.
- Commits up to RT_NUM arch-reg → physical-tag mappings per cycle.
- Reports each displaced tag (Told) so the free list can reclaim it.
- On rollback, streams the committed table back to the speculative map table in RST_BW-entry beats over multiple cycles.
- Sits between the ROB retire port, the free list and the map table.

Parameters:
RT_NUM, 2, retire channels per cycle
ARCH_REGS, 32, architectural registers (table entries)
PHY_REGS, 64, physical registers; TAG_W = $clog2(PHY_REGS)
RST_BW, 4, entries restored per beat; ARCH_REGS must be a multiple of RST_BW
ZERO_REG, 1, 1 = arch reg 0 is hardwired (writes to it are ignored)

Ports:
clk_i  in  1  clock, all state updates on posedge
rst_i  in  1  synchronous active-high reset
rt_amt_i  in  RT_NUM x {wr_en 1, arch_reg $clog2(ARCH_REGS), phy_tag TAG_W}  retire commit requests; channel 0 is oldest
rt_rdy_o  out  1  1 = commits accepted this cycle
rel_valid_o  out  RT_NUM  released-tag valid per channel
rel_tag_o  out  RT_NUM x TAG_W  released (previous) tag per channel
rollback_i  in  1  rollback request, single-cycle pulse
amt_o  out  ARCH_REGS x TAG_W  current registered table contents
rst_valid_o  out  1  restore beat valid
rst_idx_o  out  $clog2(ARCH_REGS)  first arch reg of the beat
rst_tags_o  out  RST_BW x TAG_W  tags for rst_idx_o .. rst_idx_o+RST_BW-1
rst_done_o  out  1  high on the final restore beat only
busy_o  out  1  high while in RESTORE

Behaviour:
- Reset:
  - amt[i] = i for every entry.
  - State = IDLE, beat counter = 0.
  - rst_valid_o, rst_done_o and busy_o = 0; rt_rdy_o = 1.
  - rel_valid_o = 0 (no commits while rst_i is high).
- FSM states: IDLE and RESTORE.
  - IDLE → RESTORE when rollback_i = 1 at a posedge.
  - RESTORE → IDLE after beat ARCH_REGS/RST_BW − 1.
  - rollback_i is ignored while in RESTORE.
- Commit (IDLE only, rt_rdy_o = 1):
  - Channel c with wr_en = 1 writes amt[arch_reg] = phy_tag at the posedge; amt_o reflects the write next cycle.
  - Within a group, same arch_reg on several channels: the highest channel index wins the final write.
  - ZERO_REG = 1 and arch_reg = 0: no write, rel_valid_o[c] = 0.
- Release (combinational, same cycle as the commit):
  - rel_valid_o[c] = wr_en[c] for every non-ignored channel.
  - rel_tag_o[c] = amt[arch_reg] as registered before this edge.
  - Forwarding: if a lower channel k < c in the same group writes the same arch_reg, rel_tag_o[c] = the phy_tag of the highest such k. No tag is ever released twice.
- Rollback cycle:
  - Commits presented in the same cycle as rollback_i are applied and released normally (the mispredicted branch retires).
  - The restore stream reflects those commits.
- RESTORE:
  - rt_rdy_o = 0; wr_en on every channel is ignored; rel_valid_o = 0.
  - Upstream must hold its commits until rt_rdy_o returns to 1.
  - Beat n is on the cycles after entering RESTORE, starting n = 0; beats are contiguous, with no backpressure.
  - Each beat: rst_valid_o = 1, rst_idx_o = n*RST_BW, rst_tags_o[j] = amt[n*RST_BW + j].
  - Total of ARCH_REGS/RST_BW beats; rst_done_o = 1 on the last beat.
  - rt_rdy_o = 1 again on the cycle after the last beat.
- Restore output registering: outputs are registered from the FSM and counter. The first beat appears exactly 1 cycle after the rollback_i edge.
- Reset mid-RESTORE: abort immediately, restore identity mapping, state = IDLE, no rst_done_o pulse.
- Widths: the beat counter saturates at its last index before wrapping to 0 on the transition to IDLE. No arithmetic overflow is possible, given ARCH_REGS % RST_BW == 0.

Test Plan:
- Reset then release: amt_o[i] == i for i = 0..31; rel_valid_o = 0; rt_rdy_o = 1; busy_o = 0.
- Distinct commits: ch0 {1, r3, 40}, ch1 {1, r5, 41} → rel_tag_o = {3, 5}, rel_valid_o = 2'b11; next cycle amt_o[3] = 40, amt_o[5] = 41.
- Same-register group: ch0 {1, r7, 50}, ch1 {1, r7, 51} → rel_tag_o[0] = 7, rel_tag_o[1] = 50; next cycle amt_o[7] = 51. Separately, a commit to r0 → no change, rel_valid_o[c] = 0.
- Rollback with commit, after the two scenarios above: rollback_i with ch0 {1, r2, 60} → 8 beats with rst_idx_o = 0, 4, ..., 28; beat 0 tags = {0, 1, 60, 40}; beat 1 tags = {4, 41, 6, 51}; rst_done_o only on beat 7; busy_o high for 8 cycles.
- Stall during restore: wr_en = 1 on both channels during RESTORE → amt_o unchanged, rel_valid_o = 0. A second rollback_i pulse mid-stream is ignored (still exactly 8 beats).
- Reset at beat 3 → next cycle busy_o = 0, rst_valid_o = 0, amt_o identity, no rst_done_o.
